// File: rtl/pipe_conv_pkg.sv
// Shared types and width derivations for the streaming convolution engine.
package pipe_conv_pkg;

  typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_FLUSH} state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Sum of TAPS full-width products never overflows at this width.
  function automatic int acc_w(input int data_w, input int taps);
    return 2 * data_w + clog2(taps);
  endfunction

  function automatic int len_w(input int taps);
    return clog2(taps + 1);
  endfunction

endpackage

// File: rtl/conv_mac_tree.sv
// Registered multiplier array (stage 1) followed by a registered adder tree (stage 2).
module conv_mac_tree
  import pipe_conv_pkg::*;
#(
  parameter  int TAPS   = 21,
  parameter  int DATA_W = 21,
  parameter  int SIGNED = 0,
  localparam int ACC_W  = acc_w(DATA_W, TAPS),
  localparam int PW     = 2 * DATA_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en_i,
  input  logic                           vld_i,
  input  logic                           last_i,
  input  logic [TAPS-1:0][DATA_W-1:0]    h_i,
  input  logic [TAPS-1:0][DATA_W-1:0]    x_i,
  output logic                           vld_o,
  output logic                           last_o,
  output logic [ACC_W-1:0]               sum_o,
  output logic                           busy_o
);

  logic [TAPS-1:0][PW-1:0] prod_d, prod_q;
  logic [ACC_W-1:0]        sum_d, sum_q;
  logic [2:1]              vld_pipe_q, last_pipe_q;

  function automatic logic [PW-1:0] ext_op(input logic [DATA_W-1:0] v);
    if (SIGNED != 0) return {{DATA_W{v[DATA_W-1]}}, v};
    else             return {{DATA_W{1'b0}}, v};
  endfunction

  // Multiplying the extended operands modulo 2^PW gives the exact product in both modes.
  for (genvar k = 0; k < TAPS; k++) begin : g_mul
    assign prod_d[k] = ext_op(h_i[k]) * ext_op(x_i[k]);
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < TAPS; k++) begin
      if (SIGNED != 0) sum_d = sum_d + ACC_W'($signed(prod_q[k]));
      else             sum_d = sum_d + ACC_W'(prod_q[k]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q      <= '0;
      sum_q       <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
    end else if (en_i) begin
      prod_q      <= prod_d;
      sum_q       <= sum_d;
      vld_pipe_q  <= {vld_pipe_q[1], vld_i};
      last_pipe_q <= {last_pipe_q[1], last_i & vld_i};
    end
  end

  assign vld_o  = vld_pipe_q[2];
  assign last_o = last_pipe_q[2];
  assign sum_o  = sum_q;
  assign busy_o = |vld_pipe_q;

endmodule

// File: rtl/pipe_conv_stream.sv
// Streaming zero-padded 1-D convolution: coefficient load FSM, delay line and handshakes.
module pipe_conv_stream
  import pipe_conv_pkg::*;
#(
  parameter  int DATA_W = 21,
  parameter  int TAPS   = 21,
  parameter  int SIGNED = 0,
  localparam int ACC_W  = acc_w(DATA_W, TAPS),
  localparam int LEN_W  = len_w(TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              coef_valid,
  output logic              coef_ready,
  input  logic [DATA_W-1:0] coef_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ACC_W-1:0]  m_data,
  output logic              m_last,
  output logic              busy
);

  state_e                      state_q, state_d;
  logic [LEN_W-1:0]            len_q, len_d, idx_q, idx_d, flush_q, flush_d;
  logic [LEN_W-1:0]            cfg_eff, ld_len;
  logic [TAPS-1:0][DATA_W-1:0] h_q, h_d, dl_q, dl_d, win;
  logic                        open_q, open_d;
  logic                        en, in_vld, in_last, pipe_busy;

  assign en      = !m_valid || m_ready;
  assign cfg_eff = (cfg_len == '0)              ? LEN_W'(1)    :
                   (cfg_len > LEN_W'(TAPS))     ? LEN_W'(TAPS) : cfg_len;
  assign ld_len  = (idx_q == '0) ? cfg_eff : len_q;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    flush_d    = flush_q;
    h_d        = h_q;
    dl_d       = dl_q;
    open_d     = open_q;
    coef_ready = 1'b0;
    s_ready    = 1'b0;
    in_vld     = 1'b0;
    in_last    = 1'b0;
    // Window seen by the multipliers: new sample (or injected zero) at tap 0.
    win[0] = (state_q == ST_FLUSH) ? '0 : s_data;
    for (int k = 1; k < TAPS; k++) win[k] = dl_q[k-1];

    unique case (state_q)
      ST_LOAD: begin
        coef_ready = 1'b1;
        if (coef_valid) begin
          if (idx_q == '0) len_d = cfg_eff;
          h_d[idx_q] = coef_data;
          idx_d      = idx_q + 1'b1;
          if (idx_q == ld_len - 1'b1) begin
            state_d = ST_RUN;
            idx_d   = '0;
            dl_d    = '0;
            for (int k = 0; k < TAPS; k++)
              if (k > int'(idx_q)) h_d[k] = '0;
          end
        end
      end
      ST_RUN: begin
        coef_ready = !open_q;
        s_ready    = en && !(coef_valid && !open_q);
        if (coef_valid && !open_q) begin
          h_d[0] = coef_data;
          len_d  = cfg_eff;
          idx_d  = LEN_W'(1);
          if (cfg_eff == LEN_W'(1)) begin
            idx_d = '0;
            dl_d  = '0;
            for (int k = 1; k < TAPS; k++) h_d[k] = '0;
          end else begin
            state_d = ST_LOAD;
          end
        end else if (s_valid && en) begin
          in_vld = 1'b1;
          dl_d   = win;
          open_d = 1'b1;
          if (s_last) begin
            if (len_q == LEN_W'(1)) begin
              in_last = 1'b1;
              open_d  = 1'b0;
              dl_d    = '0;
            end else begin
              state_d = ST_FLUSH;
              flush_d = len_q - 1'b1;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (en) begin
          in_vld  = 1'b1;
          dl_d    = win;
          flush_d = flush_q - 1'b1;
          if (flush_q == LEN_W'(1)) begin
            in_last = 1'b1;
            dl_d    = '0;
            open_d  = 1'b0;
            state_d = ST_RUN;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_LOAD;
      len_q   <= LEN_W'(1);
      idx_q   <= '0;
      flush_q <= '0;
      h_q     <= '0;
      dl_q    <= '0;
      open_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      flush_q <= flush_d;
      h_q     <= h_d;
      dl_q    <= dl_d;
      open_q  <= open_d;
    end
  end

  conv_mac_tree #(.TAPS(TAPS), .DATA_W(DATA_W), .SIGNED(SIGNED)) u_mac (
    .clk    (clk),
    .rst    (rst),
    .en_i   (en),
    .vld_i  (in_vld),
    .last_i (in_last),
    .h_i    (h_q),
    .x_i    (win),
    .vld_o  (m_valid),
    .last_o (m_last),
    .sum_o  (m_data),
    .busy_o (pipe_busy)
  );

  assign busy = open_q || (state_q == ST_FLUSH) || pipe_busy;

endmodule

// File: doc/pipe_conv_stream.md
Name: pipe_conv_stream

Overview:
Parametrised, streaming, pipelined 1-D linear convolution engine with full zero-padding. A coefficient vector h of up to TAPS words is loaded once and retained across frames. Each sample frame x of arbitrary length L produces y[n] = sum h[k]*x[n-k], for L+len-1 output samples, using ready/valid handshakes. It is the parametrised successor to the fixed 21x21 convolution block and feeds downstream DSP stages in the pipeline.

Parameters:
DATA_W, 21, width of coefficients and samples.
TAPS, 21, maximum coefficient count (delay-line depth).
SIGNED, 0, 0 = unsigned arithmetic, 1 = two's-complement arithmetic.
ACC_W, 2*DATA_W+clog2(TAPS), output width (derived; never overridden).

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
cfg_len  in  clog2(TAPS+1)  active tap count; sampled when a coefficient load starts
coef_valid  in  1  coefficient word valid
coef_ready  out  1  coefficient word accepted when both high
coef_data  in  DATA_W  coefficient h[k]; k ascending from 0
s_valid  in  1  sample valid
s_ready  out  1  sample accepted when both high
s_data  in  DATA_W  sample x[n]
s_last  in  1  marks the final sample of a frame
m_valid  out  1  result valid
m_ready  in  1  downstream accept
m_data  out  ACC_W  result y[n]
m_last  out  1  marks the final result of a frame
busy  out  1  a frame is open, FLUSH is active, or the pipeline holds data

Behaviour:
- Reset (rst low, asynchronous):
  - State = LOAD; load index = 0.
  - h[] and the delay line are cleared.
  - All pipeline valids are cleared.
  - m_valid = 0, m_data = 0, m_last = 0, s_ready = 0, busy = 0, coef_ready = 1.
- cfg_len handling: a value of 0 is treated as 1; a value greater than TAPS is treated as TAPS. The value is latched as len when the first coefficient word is accepted.
- LOAD state:
  - coef_ready = 1 and s_ready = 0.
  - Each accepted word is written to h[idx], then idx increments.
  - Accepting word len-1 moves the block to RUN; h[k] for k >= len is forced to 0, and the delay line is cleared.
- RUN state:
  - s_ready = pipeline enable AND NOT (coef_valid AND no frame open).
  - An accepted sample shifts into delay line position 0 and opens a frame.
  - Accepting s_last moves to FLUSH, or, if len = 1, closes the frame and stays in RUN.
  - coef_valid with no frame open takes priority over s_valid: the word is written to h[0], idx = 1, len is latched, and the block goes to LOAD (or stays in RUN if len = 1).
  - coef_valid while a frame is open is ignored: coef_ready = 0.
- FLUSH state:
  - Injects len-1 zero samples, one per enabled cycle; no input is accepted.
  - The final injection carries the last tag, clears the delay line, closes the frame, and returns to RUN.
- Pipeline:
  - Stage 1 registers the TAPS products h[k]*x[n-k].
  - Stage 2 registers the adder-tree sum into m_data / m_valid / m_last.
  - Latency from an accepted sample (or injected zero) to m_valid is 2 cycles.
- Backpressure: enable = NOT m_valid OR m_ready. Every stage, the delay line and the FLUSH counter freeze while enable = 0. No output sample is dropped or duplicated.
- Output count per frame is exactly L+len-1; m_last is asserted on the last of these only.
- Arithmetic:
  - Products are 2*DATA_W wide and the sum is ACC_W wide, so there is no overflow at full scale.
  - With SIGNED = 1, operands and products are sign-extended.
  - With SIGNED = 0, zero-extended.
- Single-sample frame (s_last on the first sample): yields len outputs.
- Frames are independent; no sample from a previous frame contributes to the next frame's outputs.
- Reset asserted mid-frame or mid-FLUSH aborts immediately: outputs are at their reset values and coefficients must be reloaded.

Decomposition:
- Package pipe_conv_pkg holds:
  - the state enum (LOAD, RUN, FLUSH);
  - a clog2 constant function;
  - the ACC_W and length-width derivations.
- Sub-module conv_mac_tree (TAPS, DATA_W, SIGNED) holds the registered multiplier array and the registered adder tree, with an enable input and valid/last sideband. The FSM, delay line and handshakes stay in pipe_conv_stream.

Test Plan:
1. len=3, h=1,2,3; frame x=1,1,1,1 with s_last on the 4th sample, m_ready=1 -> m_data 1,3,6,6,5,3; m_last on the 6th output; first m_valid 2 cycles after the first accept.
2. Same as test 1 with m_ready toggling 1,0,1,0 -> identical data and m_last; s_ready low during stalls; no drop or duplicate.
3. len=1, h=5; frame x=2,3 (last) -> 10,15, m_last on 15, no FLUSH cycles; then cfg_len=0, coef 7 -> len 1, x=1 (last) -> 7, m_last.
4. SIGNED=1, DATA_W=8, len=2, h=-1,2; x=-128,127 (last) -> 128, -383, 254.
5. h=1,2,3 retained; frame [1,1] then frame [2] back-to-back -> 1,3,5,3 then 2,4,6 with no leakage. Then unsigned, TAPS=21, all h and x = 2^21-1 -> full-scale sums exact (no wrap).
6. rst driven low during FLUSH -> m_valid=0, busy=0 immediately. After release, coef_ready=1 and s_ready=0 until len coefficients are reloaded.
